ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Parametrised instruction-fetch unit: sequences the PC and issues one-outstanding request/acknowledge fetches to the ICache.
- Consults the branch predictor combinationally in the acknowledge cycle.
- Buffers fetched instructions in a DEPTH-entry circular queue; the decoder drains the queue with a valid/ready handshake.
- Accepts ROB mispredict redirects, which flush the queue and cancel in-flight fetches.
- Sits between the ICache, predictor, decoder and ROB.

Parameters:
- ADDR_W, 32, PC/address width.
- INSTR_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; 0 freezes all state.
- jump_wrong  in  1  ROB redirect pulse (mispredict).
- jump_pc_from_rob  in  ADDR_W  redirect target.
- icache_req  out  1  fetch request, held until ack.
- icache_addr  out  ADDR_W  fetch address, stable while icache_req=1.
- icache_ack  in  1  one-cycle pulse; icache_instr valid this cycle.
- icache_instr  in  INSTR_W  fetched instruction.
- pred_instr  out  INSTR_W  equals icache_instr (combinational).
- pred_pc  out  ADDR_W  equals icache_addr (combinational).
- pred_taken  in  1  predictor: taken branch/jump.
- pred_target  in  ADDR_W  predicted target.
- dec_valid  out  1  queue head valid.
- dec_ready  in  1  decoder accepts head.
- dec_instr  out  INSTR_W  head instruction.
- dec_pc  out  ADDR_W  head PC.
- dec_pred_taken  out  1  head prediction bit.
- queue_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC; state=IDLE; head=tail=0; count=0; icache_req=0; icache_addr=RESET_PC; dec_valid=0; queue_count=0.
- rdy=0: no register changes; outputs hold. Contract: icache_ack is never asserted while rdy=0.
- Credit rule: a request may be issued only if count + outstanding(0/1) < DEPTH, evaluated after this cycle's dequeue.
- FSM state IDLE: if credit available and no jump_wrong, then next cycle icache_req=1, icache_addr=pc; go to FETCH.
- FSM state FETCH: on icache_ack without jump_wrong:
  - enqueue {icache_instr, icache_addr, pred_taken} at tail;
  - pc <= pred_taken ? pred_target : icache_addr+4 (mod 2^ADDR_W).
  - If credit remains after the enqueue, stay in FETCH with icache_req=1 and the new address next cycle (back-to-back, no bubble); otherwise drop icache_req and go to IDLE.
- FSM state DROP: a request was cancelled; icache_req held with its old address until icache_ack; data is discarded. Then go to IDLE, or to FETCH at the new pc if credit is available.
- jump_wrong (priority over everything):
  - queue cleared (head=tail=0, count=0, dec_valid=0 next cycle);
  - pc <= jump_pc_from_rob.
  - If in FETCH with no ack this cycle, go to DROP.
  - If ack arrives in the same cycle, discard the data; go to FETCH at jump_pc_from_rob next cycle.
  - In IDLE, go to FETCH at jump_pc_from_rob next cycle.
- Dequeue: when dec_valid & dec_ready, advance head and decrement count. An enqueue and a dequeue in the same cycle leave count unchanged.
- Decoder outputs: dec_valid = (count != 0); dec_* driven from registered storage at head. The first instruction appears 1 cycle after its ack.
- Pointers wrap modulo DEPTH. The full condition is count == DEPTH, so the queue never overflows by construction.
- Latency: redirect to first request = 1 cycle (IDLE) or wait-for-ack+1 (DROP).

Test Plan:
- Reset then run, ICache ack latency 2, dec_ready=1, pred_taken=0 -> requests at 0x0, 0x4, 0x8; dec_pc sequence 0x0, 0x4, 0x8 in order; each appears 1 cycle after its ack.
- dec_ready=0, DEPTH=4 -> exactly 4 acks enqueued, icache_req falls, queue_count=4. Raising dec_ready for one cycle -> one new request at 0x10.
- pred_taken=1, pred_target=0x100 on the ack for 0x8 -> next icache_addr=0x100; that entry has dec_pred_taken=1.
- jump_wrong with jump_pc_from_rob=0x200 while a request for 0xC is outstanding -> queue empties; the 0xC data is discarded at ack; next request is 0x200; no 0xC reaches the decoder.
- jump_wrong in the same cycle as icache_ack -> data not enqueued; next icache_addr = redirect target.
- rdy=0 for 5 cycles mid-fetch with dec_ready=1 -> queue_count, icache_addr and dec_* are unchanged; operation resumes identically when rdy=1.
- rst asserted mid-FETCH -> all outputs go immediately to their reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch unit: PC sequencing, one-outstanding ICache fetches and a
// DEPTH-entry circular queue feeding the decoder, with ROB redirect/flush.
//
//   state | meaning
//   IDLE  | no request outstanding; waiting for queue credit
//   FETCH | request outstanding; its data will be enqueued
//   DROP  | request outstanding but cancelled by a redirect; data discarded
module ifetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       jump_wrong,
    input  logic [ADDR_W-1:0]          jump_pc_from_rob,
    output logic                       icache_req,
    output logic [ADDR_W-1:0]          icache_addr,
    input  logic                       icache_ack,
    input  logic [INSTR_W-1:0]         icache_instr,
    output logic [INSTR_W-1:0]         pred_instr,
    output logic [ADDR_W-1:0]          pred_pc,
    input  logic                       pred_taken,
    input  logic [ADDR_W-1:0]          pred_target,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [INSTR_W-1:0]         dec_instr,
    output logic [ADDR_W-1:0]          dec_pc,
    output logic                       dec_pred_taken,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                req_q;
    logic [ADDR_W-1:0]   addr_q;

    logic [INSTR_W-1:0]  mem_instr [DEPTH];
    logic [ADDR_W-1:0]   mem_pc    [DEPTH];
    logic                mem_taken [DEPTH];

    logic                ack;
    logic                deq;
    logic                enq;
    logic [CNT_W-1:0]    count_deq;
    logic [CNT_W-1:0]    count_next;
    logic [ADDR_W-1:0]   next_pc;

    // An ack is only meaningful while a request is actually outstanding.
    assign ack        = icache_ack && req_q;
    assign deq        = (count != '0) && dec_ready;
    assign enq        = rdy && ack && !jump_wrong && (state == FETCH);
    assign count_deq  = count - CNT_W'(deq);
    assign count_next = count_deq + CNT_W'(enq);
    assign next_pc    = pred_taken ? pred_target : addr_q + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            req_q  <= 1'b0;
            addr_q <= RESET_PC;
        end else if (rdy) begin
            if (jump_wrong) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                pc    <= jump_pc_from_rob;
                if (state == IDLE || ack) begin
                    state  <= FETCH;
                    req_q  <= 1'b1;
                    addr_q <= jump_pc_from_rob;
                end else begin
                    // request stays up at its old address until the ICache answers
                    state <= DROP;
                end
            end else begin
                if (deq) head <= head + PTR_W'(1);
                if (enq) tail <= tail + PTR_W'(1);
                count <= count_next;
                case (state)
                    IDLE: begin
                        if (count_deq < CNT_W'(DEPTH)) begin
                            state  <= FETCH;
                            req_q  <= 1'b1;
                            addr_q <= pc;
                        end
                    end
                    FETCH: begin
                        if (ack) begin
                            pc <= next_pc;
                            if (count_next < CNT_W'(DEPTH)) begin
                                req_q  <= 1'b1;
                                addr_q <= next_pc;
                            end else begin
                                state <= IDLE;
                                req_q <= 1'b0;
                            end
                        end
                    end
                    DROP: begin
                        if (ack) begin
                            if (count_deq < CNT_W'(DEPTH)) begin
                                state  <= FETCH;
                                req_q  <= 1'b1;
                                addr_q <= pc;
                            end else begin
                                state <= IDLE;
                                req_q <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        req_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_instr[tail] <= icache_instr;
            mem_pc[tail]    <= addr_q;
            mem_taken[tail] <= pred_taken;
        end
    end

    assign icache_req     = req_q;
    assign icache_addr    = addr_q;
    assign pred_instr     = icache_instr;
    assign pred_pc        = addr_q;
    assign dec_valid      = (count != '0);
    assign dec_instr      = mem_instr[head];
    assign dec_pc         = mem_pc[head];
    assign dec_pred_taken = mem_taken[head];
    assign queue_count    = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: an ICache/predictor model checks request
// addresses, and a monitor checks every decoder handshake against expectations.
module tb_ifetch_queue;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int ACK_LAT = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               taken;
    } dec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdy = 1'b1;
    logic               jump_wrong = 1'b0;
    logic [ADDR_W-1:0]  jump_pc_from_rob = '0;
    logic               icache_req;
    logic [ADDR_W-1:0]  icache_addr;
    logic               icache_ack = 1'b0;
    logic [INSTR_W-1:0] icache_instr = '0;
    logic [INSTR_W-1:0] pred_instr;
    logic [ADDR_W-1:0]  pred_pc;
    logic               pred_taken = 1'b0;
    logic [ADDR_W-1:0]  pred_target = '0;
    logic               dec_valid;
    logic               dec_ready = 1'b0;
    logic [INSTR_W-1:0] dec_instr;
    logic [ADDR_W-1:0]  dec_pc;
    logic               dec_pred_taken;
    logic [$clog2(DEPTH):0] queue_count;

    int vectors = 0;
    int miscompares = 0;
    int acks_left = 0;
    int wait_cnt = 0;
    logic [ADDR_W-1:0] taken_pc = 32'h1;
    logic [ADDR_W-1:0] taken_target = 32'h100;

    logic [ADDR_W-1:0] exp_req[$];
    dec_t              exp_dec[$];

    ifetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .jump_wrong(jump_wrong), .jump_pc_from_rob(jump_pc_from_rob),
        .icache_req(icache_req), .icache_addr(icache_addr),
        .icache_ack(icache_ack), .icache_instr(icache_instr),
        .pred_instr(pred_instr), .pred_pc(pred_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_pred_taken(dec_pred_taken),
        .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] a);
        exp_req.push_back(a);
    endtask

    task automatic push_dec(input logic [ADDR_W-1:0] a, input logic t);
        dec_t d;
        d.pc    = a;
        d.instr = ~a;
        d.taken = t;
        exp_dec.push_back(d);
    endtask

    task automatic wait_acks(input int target, input string name);
        int n = 0;
        while (acks_left != target && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(acks_left), 64'(target));
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (dec_valid && n < 200) begin
            step();
            n++;
        end
        check(name, 64'(dec_valid), 64'd0);
    endtask

    task automatic check_empty(input string name);
        check({name, "_dec_left"}, 64'(exp_dec.size()), 64'd0);
        check({name, "_req_left"}, 64'(exp_req.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        jump_wrong = 1'b0;
        dec_ready = 1'b0;
        rdy = 1'b1;
        acks_left = 0;
        taken_pc = 32'h1;
        exp_req.delete();
        exp_dec.delete();
        step();
        step();
        rst = 1'b1;
    endtask

    // ICache + predictor model; evaluated after stimulus settles each cycle.
    always begin
        @(negedge clk);
        #2;
        icache_ack = 1'b0;
        pred_taken = 1'b0;
        if (!rst) begin
            wait_cnt = 0;
        end else if (rdy && icache_req) begin
            if (wait_cnt >= ACK_LAT - 1 && acks_left > 0) begin
                icache_ack   = 1'b1;
                icache_instr = ~icache_addr;
                pred_taken   = (icache_addr == taken_pc);
                pred_target  = taken_target;
                acks_left--;
                wait_cnt = 0;
                vectors++;
                if (exp_req.size() == 0) begin
                    miscompares++;
                    $display("FAIL req_addr: got 0x%0h, expected no request", icache_addr);
                end else begin
                    logic [ADDR_W-1:0] e;
                    e = exp_req.pop_front();
                    if (icache_addr !== e) begin
                        miscompares++;
                        $display("FAIL req_addr: got 0x%0h, expected 0x%0h", icache_addr, e);
                    end
                end
            end else if (wait_cnt < ACK_LAT - 1) begin
                wait_cnt++;
            end
        end
    end

    // Decoder-side monitor: compares each accepted head entry.
    always begin
        @(negedge clk);
        #3;
        if (rst && rdy && !jump_wrong && dec_valid && dec_ready) begin
            vectors++;
            if (exp_dec.size() == 0) begin
                miscompares++;
                $display("FAIL dec_entry: got pc 0x%0h, expected none", dec_pc);
            end else begin
                dec_t e;
                e = exp_dec.pop_front();
                if (dec_pc !== e.pc || dec_instr !== e.instr || dec_pred_taken !== e.taken) begin
                    miscompares++;
                    $display("FAIL dec_entry: got pc 0x%0h instr 0x%0h t %0b, expected pc 0x%0h instr 0x%0h t %0b",
                             dec_pc, dec_instr, dec_pred_taken, e.pc, e.instr, e.taken);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        #1 rst = 1'b0;
        #1;
        check("rst_req", 64'(icache_req), 64'd0);
        check("rst_addr", 64'(icache_addr), 64'd0);
        check("rst_valid", 64'(dec_valid), 64'd0);
        check("rst_count", 64'(queue_count), 64'd0);

        // sequential fetch, decoder always ready
        do_reset();
        dec_ready = 1'b1;
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        push_dec(32'h0, 1'b0); push_dec(32'h4, 1'b0); push_dec(32'h8, 1'b0);
        acks_left = 3;
        wait_acks(2, "t1_first_ack");
        check("t1_first_valid", 64'(dec_valid), 64'd1);
        check("t1_first_pc", 64'(dec_pc), 64'h0);
        wait_acks(0, "t1_acks");
        wait_drain("t1_drain");
        check("t1_next_addr", 64'(icache_addr), 64'hC);
        check_empty("t1");

        // full queue with stalled decoder, then one credit
        do_reset();
        push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'hC); push_req(32'h10);
        push_dec(32'h0, 1'b0); push_dec(32'h4, 1'b0); push_dec(32'h8, 1'b0);
        push_dec(32'hC, 1'b0); push_dec(32'h10, 1'b0);
        acks_left = 10;
        wait_acks(6, "t2_acks4");
        step(); step(); step();
        check("t2_exact4", 64'(acks_left), 64'd6);
        check("t2_req_low", 64'(icache_req), 64'd0);
        check("t2_full", 64'(queue_count), 64'd4);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("t2_credit_req", 64'(icache_req), 64'd1);
        check("t2_credit_addr", 64'(icache_addr), 64'h10);
        check("t2_count3", 64'(queue_count), 64'd3);
        wait_acks(5, "t2_ack10");
        step();
        check("t2_full_again", 64'(queue_count), 64'd4);
        check("t2_req_low2", 64'(icache_req), 64'd0);
        acks_left = 0;
        dec_ready = 1'b1;
        wait_drain("t2_drain");
        check_empty("t2");

        // predicted-taken branch at 0x8
        do_reset();
        taken_pc = 32'h8;
        dec_ready = 1'b1;
        push_req(32'h0); push_req(32'h4); push_req(32'h8); push_req(32'h100);
        push_dec(32'h0, 1'b0); push_dec(32'h4, 1'b0); push_dec(32'h8, 1'b1); push_dec(32'h100, 1'b0);
        acks_left = 4;
        wait_acks(0, "t3_acks");
        wait_drain("t3_drain");
        check("t3_next_addr", 64'(icache_addr), 64'h104);
        check_empty("t3");

        // redirect while 0xC is outstanding
        do_reset();
        push_req(32'h0); push_req(32'h4); push_req(32'h8);
        acks_left = 3;
        wait_acks(0, "t4_acks");
        step(); step();
        check("t4_count3", 64'(queue_count), 64'd3);
        check("t4_pending_addr", 64'(icache_addr), 64'hC);
        jump_pc_from_rob = 32'h200;
        jump_wrong = 1'b1;
        step();
        jump_wrong = 1'b0;
        check("t4_flush_count", 64'(queue_count), 64'd0);
        check("t4_flush_valid", 64'(dec_valid), 64'd0);
        check("t4_drop_req", 64'(icache_req), 64'd1);
        check("t4_drop_addr", 64'(icache_addr), 64'hC);
        push_req(32'hC); push_req(32'h200); push_req(32'h204);
        push_dec(32'h200, 1'b0); push_dec(32'h204, 1'b0);
        dec_ready = 1'b1;
        acks_left = 3;
        wait_acks(0, "t4_acks2");
        wait_drain("t4_drain");
        check("t4_next_addr", 64'(icache_addr), 64'h208);
        check_empty("t4");

        // redirect coincident with ack
        do_reset();
        dec_ready = 1'b1;
        push_req(32'h0); push_req(32'h4);
        push_dec(32'h0, 1'b0); push_dec(32'h4, 1'b0);
        acks_left = 2;
        wait_acks(0, "t5_acks");
        wait_drain("t5_drain");
        step(); step();
        push_req(32'h8);
        jump_pc_from_rob = 32'h300;
        jump_wrong = 1'b1;
        acks_left = 1;
        step();
        jump_wrong = 1'b0;
        check("t5_acked", 64'(acks_left), 64'd0);
        check("t5_redir_req", 64'(icache_req), 64'd1);
        check("t5_redir_addr", 64'(icache_addr), 64'h300);
        check("t5_count0", 64'(queue_count), 64'd0);
        push_req(32'h300);
        push_dec(32'h300, 1'b0);
        acks_left = 1;
        wait_acks(0, "t5_acks2");
        wait_drain("t5_drain2");
        check_empty("t5");

        // rdy freeze mid-fetch
        do_reset();
        push_req(32'h0); push_req(32'h4);
        push_dec(32'h0, 1'b0); push_dec(32'h4, 1'b0);
        acks_left = 2;
        wait_acks(0, "t6_acks");
        step(); step(); step();
        rdy = 1'b0;
        dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t6_count", 64'(queue_count), 64'd2);
            check("t6_addr", 64'(icache_addr), 64'h8);
            check("t6_req", 64'(icache_req), 64'd1);
            check("t6_dec_pc", 64'(dec_pc), 64'h0);
            check("t6_dec_instr", 64'(dec_instr), 64'hFFFF_FFFF);
        end
        rdy = 1'b1;
        push_req(32'h8); push_req(32'hC); push_req(32'h10);
        push_dec(32'h8, 1'b0); push_dec(32'hC, 1'b0); push_dec(32'h10, 1'b0);
        acks_left = 3;
        wait_acks(0, "t6_acks2");
        wait_drain("t6_drain");
        check_empty("t6");

        // asynchronous reset mid-FETCH
        do_reset();
        push_req(32'h0);
        acks_left = 1;
        wait_acks(0, "t7_acks");
        step();
        check("t7_pre_req", 64'(icache_req), 64'd1);
        check("t7_pre_addr", 64'(icache_addr), 64'h4);
        check("t7_pre_count", 64'(queue_count), 64'd1);
        rst = 1'b0;
        #1;
        check("t7_req", 64'(icache_req), 64'd0);
        check("t7_addr", 64'(icache_addr), 64'h0);
        check("t7_valid", 64'(dec_valid), 64'd0);
        check("t7_count", 64'(queue_count), 64'd0);
        exp_req.delete();
        exp_dec.delete();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
